// File: rtl/fetch_stage_pkg.sv
// Shared CPU package: fetch FSM encoding, IF/ID bundle,
// reset/memory defaults and the fetch-address legality check.
package fetch_stage_pkg;

  localparam int ILEN = 32;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam int              IMEM_WORDS_DEF = 2048;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

  function automatic logic pc_is_bad(
    input logic [XLEN-1:0] pc,
    input int              words
  );
    logic [XLEN-1:0] idx;
    idx = {2'b00, pc[XLEN-1:2]};
    return (pc[1:0] != 2'b00) || (idx >= XLEN'(words));
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load captures a bundle,
// flush drops the valid bit and leaves the data as-is.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect,
// stall, sticky fetch-fault and IF/ID capture.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic        im_r,
  input  logic [31:0] instr_in,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc4;
  logic         run;
  logic         bad_pc;
  logic         capture;
  logic         flush;
  if_id_t       id_d;
  if_id_t       id_q;

  assign run     = (state == ST_RUN);
  assign bad_pc  = pc_is_bad(pc, IMEM_WORDS);
  assign pc4     = pc + 32'd4;
  // redirect outranks both a bad PC and a stall
  assign flush   = run && (redirect || bad_pc);
  assign capture = run && !redirect && !bad_pc && !stall;

  assign pc_out = (state == ST_BOOT) ? RESET_PC : pc;
  assign im_r   = run && !bad_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (bad_pc) begin
            state    <= ST_FAULT;
            fault    <= 1'b1;
            fault_pc <= pc;
          end else if (!stall) begin
            pc          <= pc4;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_BOOT;
      endcase
    end
  end

  assign id_d = '{instr: instr_in, pc: pc, pc4: pc4};

  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (capture),
    .flush (flush),
    .d     (id_d),
    .valid (if_id_valid),
    .q     (id_q)
  );

  assign if_id_instr = id_q.instr;
  assign if_id_pc    = id_q.pc;
  assign if_id_pc4   = id_q.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational
// instruction memory returning {16'hC0DE, addr[15:0]}.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_out;
  logic        im_r;
  logic [31:0] instr_in;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign instr_in = {16'hC0DE, pc_out[15:0]};

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_out      (pc_out),
    .im_r        (im_r),
    .instr_in    (instr_in),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .fetch_count (fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc_out got %h exp 0", pc_out); end
    checks++; if ({im_r, if_id_valid, fault} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {im_r, if_id_valid, fault}); end
    checks++; if ({if_id_instr, if_id_pc, if_id_pc4} !== 96'h0) begin errors++; $display("FAIL rst_ifid got %h exp 0", {if_id_instr, if_id_pc, if_id_pc4}); end
    checks++; if ({fault_pc, fetch_count} !== 64'h0) begin errors++; $display("FAIL rst_fault_cnt got %h exp 0", {fault_pc, fetch_count}); end
    #6 rst = 1'b0;
    #1;
    checks++; if ({im_r, pc_out} !== {1'b0, 32'h0}) begin errors++; $display("FAIL boot got im_r=%b pc=%h exp 0/0", im_r, pc_out); end
  endtask

  task automatic test_fetch();
    step();
    checks++; if ({im_r, pc_out, if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL run0 got im_r=%b pc=%h v=%b exp 1/0/0", im_r, pc_out, if_id_valid); end
    step();
    checks++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h0, 32'hC0DE0000}) begin errors++; $display("FAIL cap0 got v=%b pc=%h ins=%h", if_id_valid, if_id_pc, if_id_instr); end
    checks++; if ({pc_out, if_id_pc4, fetch_count} !== {32'h4, 32'h4, 32'd1}) begin errors++; $display("FAIL cap0_pc got %h %h %0d exp 4 4 1", pc_out, if_id_pc4, fetch_count); end
    step();
    checks++; if ({if_id_pc, if_id_instr} !== {32'h4, 32'hC0DE0004}) begin errors++; $display("FAIL cap1 got pc=%h ins=%h exp 4/c0de0004", if_id_pc, if_id_instr); end
    checks++; if ({pc_out, fetch_count} !== {32'h8, 32'd2}) begin errors++; $display("FAIL cap1_pc got %h %0d exp 8 2", pc_out, fetch_count); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({pc_out, if_id_pc, fetch_count, if_id_valid} !== {32'h8, 32'h4, 32'd2, 1'b1}) begin errors++; $display("FAIL stall%0d got pc=%h id=%h cnt=%0d v=%b", i, pc_out, if_id_pc, fetch_count, if_id_valid); end
    end
    stall = 1'b0;
    step();
    checks++; if ({if_id_pc, pc_out, fetch_count} !== {32'h8, 32'hC, 32'd3}) begin errors++; $display("FAIL unstall got id=%h pc=%h cnt=%0d exp 8 c 3", if_id_pc, pc_out, fetch_count); end
  endtask

  task automatic test_redirect();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    stall = 1'b0;
    redirect = 1'b0;
    checks++; if ({pc_out, if_id_valid, fetch_count} !== {32'h40, 1'b0, 32'd3}) begin errors++; $display("FAIL redir got pc=%h v=%b cnt=%0d exp 40/0/3", pc_out, if_id_valid, fetch_count); end
    step();
    checks++; if ({if_id_pc, if_id_valid, if_id_pc4} !== {32'h40, 1'b1, 32'h44}) begin errors++; $display("FAIL redir_cap got id=%h v=%b pc4=%h", if_id_pc, if_id_valid, if_id_pc4); end
    checks++; if ({if_id_instr, fetch_count} !== {32'hC0DE0040, 32'd4}) begin errors++; $display("FAIL redir_ins got %h %0d", if_id_instr, fetch_count); end
  endtask

  task automatic test_last_word();
    redirect = 1'b1;
    redirect_pc = 32'h1FFC;
    step();
    redirect = 1'b0;
    checks++; if ({pc_out, im_r} !== {32'h1FFC, 1'b1}) begin errors++; $display("FAIL last_pc got %h im_r=%b", pc_out, im_r); end
    step();
    checks++; if ({if_id_pc, if_id_valid, if_id_instr} !== {32'h1FFC, 1'b1, 32'hC0DE1FFC}) begin errors++; $display("FAIL last_cap got %h v=%b %h", if_id_pc, if_id_valid, if_id_instr); end
    checks++; if ({pc_out, im_r, fault, fetch_count} !== {32'h2000, 1'b0, 1'b0, 32'd5}) begin errors++; $display("FAIL oob_pre got pc=%h im_r=%b f=%b cnt=%0d", pc_out, im_r, fault, fetch_count); end
    step();
    checks++; if ({fault, fault_pc, if_id_valid, im_r} !== {1'b1, 32'h2000, 1'b0, 1'b0}) begin errors++; $display("FAIL oob_fault got f=%b fpc=%h v=%b im_r=%b", fault, fault_pc, if_id_valid, im_r); end
    checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL oob_cnt got %0d exp 5", fetch_count); end
  endtask

  task automatic test_async_reset();
    #3 rst = 1'b1;
    #1;
    checks++; if ({pc_out, im_r, if_id_valid, fault} !== {32'h0, 3'b000}) begin errors++; $display("FAIL arst_a got pc=%h im_r=%b v=%b f=%b", pc_out, im_r, if_id_valid, fault); end
    checks++; if ({fault_pc, fetch_count, if_id_pc, if_id_pc4, if_id_instr} !== 160'h0) begin errors++; $display("FAIL arst_b got fpc=%h cnt=%0d id=%h", fault_pc, fetch_count, if_id_pc); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({im_r, pc_out} !== {1'b0, 32'h0}) begin errors++; $display("FAIL arst_boot got im_r=%b pc=%h", im_r, pc_out); end
    step();
    checks++; if ({im_r, pc_out, if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL arst_run got im_r=%b pc=%h v=%b", im_r, pc_out, if_id_valid); end
    step();
    checks++; if ({if_id_pc, if_id_valid, pc_out, fetch_count} !== {32'h0, 1'b1, 32'h4, 32'd1}) begin errors++; $display("FAIL arst_cap got id=%h v=%b pc=%h cnt=%0d", if_id_pc, if_id_valid, pc_out, fetch_count); end
  endtask

  task automatic test_misaligned();
    redirect = 1'b1;
    redirect_pc = 32'h2002;
    step();
    redirect = 1'b0;
    checks++; if ({pc_out, im_r, fault, if_id_valid} !== {32'h2002, 3'b000}) begin errors++; $display("FAIL mis_pre got pc=%h im_r=%b f=%b v=%b", pc_out, im_r, fault, if_id_valid); end
    step();
    checks++; if ({fault, fault_pc, im_r} !== {1'b1, 32'h2002, 1'b0}) begin errors++; $display("FAIL mis_fault got f=%b fpc=%h im_r=%b", fault, fault_pc, im_r); end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({im_r, pc_out, fault, if_id_valid} !== {1'b0, 32'h2002, 1'b1, 1'b0}) begin errors++; $display("FAIL mis_hold%0d got im_r=%b pc=%h f=%b v=%b", i, im_r, pc_out, fault, if_id_valid); end
    end
    redirect = 1'b0;
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL mis_cnt got %0d exp 1", fetch_count); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_last_word();
    test_async_reset();
    test_misaligned();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
